snake_body_server: RTL and testbench
====================================

# snake_body_server

Game-side responder to the VGA pixel scan: it holds the snake's segment coordinates, advances them on each move tick and answers every (x_pos, y_pos) query with the 2-bit `snake` code the VGA controller colours from. It also reports the head cell, current length and collision status to the game FSM. It sits beside the apple generator, and its `snake` output feeds the VGA top's `snake` input.

## Interface
- `MAX_LEN`, 16: segment register count (max snake length).
- `INIT_LEN`, 3: length after reset/start.
- `clk`  in  1: the pixel clock that drives the VGA controller, and this block's only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `x_pos`  in  10: current scan pixel column, 0..639.
- `y_pos`  in  10: current scan pixel row, 0..479.
- `move_tick`  in  1: one-cycle pulse that advances the snake one cell.
- `dir`  in  2: requested direction. 00 up, 01 down, 10 left, 11 right.
- `grow`  in  1: one-cycle pulse requesting one extra segment, raised when the apple is eaten.
- `start`  in  1: one-cycle pulse that (re)initialises and starts the game.
- `snake`  out  2: pixel code. 00 none, 01 head, 10 body, 11 wall.
- `head_x`  out  6: head cell column.
- `head_y`  out  5: head cell row.
- `length`  out  5: current segment count.
- `dead`  out  1: high after a collision, until the next start or reset.

## Operation
- Grid: 16-px cells, 40×30. Cell column = `x_pos[9:4]`, cell row = `y_pos[8:4]`.
- Wall cells: column 0, column 39, row 0, row 29.
- Segment 0 is the head. Segments 1..length-1 are body. Segments at index ≥ length are inactive.
- Init state (reset or start):
  - seg0 = (20,15), seg1 = (19,15), seg2 = (18,15).
  - Heading = right. length = INIT_LEN. Pending-grow cleared.
- FSM states: IDLE, RUN, DEAD.
  - Reset → IDLE.
  - start in any state → re-init, then RUN.
  - RUN + collision → DEAD.
  - IDLE and DEAD ignore move_tick. Positions freeze but stay displayed.
- Heading: on move_tick, `dir` is accepted unless it is the exact reverse of the current heading. A reverse request is ignored and the old heading kept.
- Move (RUN, move_tick):
  - New head = head ± 1 on the accepted axis.
  - seg[i] ← seg[i-1] for i = 1..MAX_LEN-1.
  - If pending-grow is set, length increments (saturating at MAX_LEN) and pending-grow is cleared.
- grow sets pending-grow. A grow arriving in the same cycle as move_tick is applied on that move.
- Collision check uses the new head:
  - Wall cell, or
  - Equals an active body segment 1..length-2. Include segment length-1 as well when growing, because the tail does not vacate.
  - On collision: state → DEAD and segments are not updated (the snake freezes pre-move).
- Pixel query priority: wall > head > body > none.
  - Body match = any active segment 1..length-1 equals the query cell.
  - Pixels at x ≥ 640 or y ≥ 480 return 00.

## Timing
- Pixel query: registered, latency exactly 1 cycle. `snake` at cycle n+1 reflects `x_pos`/`y_pos` at cycle n.
- A query in the same cycle as a move sees the pre-move positions. A query in the following cycle sees the new positions.
- `head_x`, `head_y`, `length`, `dead` are registered and update the cycle after the move_tick or start.
- Reset values:
  - `snake` = 00, `head_x` = 20, `head_y` = 15, `length` = 3, `dead` = 0.
  - Pending-grow = 0, heading = right, state = IDLE.
- Reset asserted mid-game: all state returns to the reset values immediately (asynchronously).
- start and move_tick in the same cycle: start wins, and no move occurs.
- grow at length = MAX_LEN: the pending flag is cleared on the next move and length stays MAX_LEN.

## Structure
- Shared package `snake_pkg` holds:
  - Cell-code constants (NONE/HEAD/BODY/WALL).
  - Direction encodings.
  - Grid constants: CELL_SHIFT = 4, GRID_W = 40, GRID_H = 30.
  - Init coordinates.
- One sub-module, `snake_cell_match`: a combinational parallel comparator of a query cell against MAX_LEN segments with an active mask. It returns head/body hit. It is instantiated twice: once for the pixel query, once for the collision check.

## Test plan
- Reset, then scan pixel (320,240) → `snake` = 01 one cycle later. Pixel (300,240) → 10. Pixel (5,5) → 11. Pixel (100,100) → 00.
- start, then 3 move_ticks with dir = 11 (right) → head (23,15), length 3. Cell (20,15) → 00.
- grow pulse, then one move_tick → length 4. grow with move_tick in the same cycle → length 5 after that tick.
- Heading right, dir = 10 (left) with move_tick → head moves right, reverse ignored.
- Drive the head to column 38, then one more right move → `dead` = 1, head stays (38,15), and further ticks have no effect. start → init positions restored and `dead` = 0.
- Length 5, turn sequence up/left/down into the body → `dead` = 1. Assert rst mid-RUN → all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants and types for the snake body server
package snake_pkg;

   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_HEAD = 2'b01;
   localparam logic [1:0] CODE_BODY = 2'b10;
   localparam logic [1:0] CODE_WALL = 2'b11;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DEAD = 2'b10
   } state_t;

   localparam int CELL_SHIFT = 4;
   localparam int GRID_W     = 40;
   localparam int GRID_H     = 30;

   localparam logic [9:0] PIX_W = 10'd640;
   localparam logic [9:0] PIX_H = 10'd480;

   localparam logic [5:0] INIT_X = 6'd20;
   localparam logic [4:0] INIT_Y = 5'd15;

   // Initial body trails straight left of the head; inactive entries just continue the line.
   function automatic logic [5:0] init_x(input int idx);
      return INIT_X - 6'(idx);
   endfunction

   function automatic logic is_wall(input logic [5:0] cx, input logic [4:0] cy);
      return (cx == 6'd0) || (cx == 6'(GRID_W - 1)) || (cy == 5'd0) || (cy == 5'(GRID_H - 1));
   endfunction

endpackage

// File: rtl/snake_cell_match.sv
// rtl/snake_cell_match.sv - parallel compare of one cell against all segments
module snake_cell_match
   import snake_pkg::*;
#(
   parameter int MAX_LEN = 16
) (
   input  logic [5:0]               cell_x,
   input  logic [4:0]               cell_y,
   input  logic [MAX_LEN-1:0][5:0]  seg_x,
   input  logic [MAX_LEN-1:0][4:0]  seg_y,
   input  logic [MAX_LEN-1:0]       active,
   output logic                     head_hit,
   output logic                     body_hit
);

   logic [MAX_LEN-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         hit[i] = active[i] && (seg_x[i] == cell_x) && (seg_y[i] == cell_y);
      end
   end

   assign head_hit = hit[0];
   assign body_hit = |hit[MAX_LEN-1:1];

endmodule

// File: rtl/snake_body_server.sv
// rtl/snake_body_server.sv - snake segment store, mover and VGA pixel responder
module snake_body_server
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic       move_tick,
   input  logic [1:0] dir,
   input  logic       grow,
   input  logic       start,
   output logic [1:0] snake,
   output logic [5:0] head_x,
   output logic [4:0] head_y,
   output logic [4:0] length,
   output logic       dead
);

   localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);
   localparam logic [4:0] LEN_INIT = 5'(INIT_LEN);

   state_t                   state;
   dir_t                     heading;
   dir_t                     acc_dir;
   logic                     pending_grow;
   logic [MAX_LEN-1:0][5:0]  seg_x;
   logic [MAX_LEN-1:0][4:0]  seg_y;

   logic [5:0]         qx, nx;
   logic [4:0]         qy, ny;
   logic               in_range;
   logic [MAX_LEN-1:0] pix_mask, col_mask;
   logic               pix_head, pix_body, col_head, col_body;
   logic               grow_eff, collide;
   logic [1:0]         pix_code;

   assign qx       = 6'(x_pos >> CELL_SHIFT);
   assign qy       = 5'(y_pos >> CELL_SHIFT);
   assign in_range = (x_pos < PIX_W) && (y_pos < PIX_H);

   // A reverse request differs from the heading only in bit 0.
   assign acc_dir  = (dir == (heading ^ 2'b01)) ? heading : dir_t'(dir);
   assign grow_eff = (pending_grow || grow) && (length < LEN_MAX);

   always_comb begin
      nx = seg_x[0];
      ny = seg_y[0];
      case (acc_dir)
         DIR_UP:    ny = seg_y[0] - 5'd1;
         DIR_DOWN:  ny = seg_y[0] + 5'd1;
         DIR_LEFT:  nx = seg_x[0] - 6'd1;
         DIR_RIGHT: nx = seg_x[0] + 6'd1;
         default:   nx = seg_x[0];
      endcase
   end

   // The tail cell only counts as an obstacle when it will not vacate this move.
   always_comb begin
      pix_mask = '0;
      col_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         pix_mask[i] = (5'(i) < length);
         col_mask[i] = (i != 0) &&
                       ((5'(i) < length - 5'd1) || (grow_eff && (5'(i) == length - 5'd1)));
      end
   end

   snake_cell_match #(.MAX_LEN(MAX_LEN)) u_pix_match (
      .cell_x   (qx),
      .cell_y   (qy),
      .seg_x    (seg_x),
      .seg_y    (seg_y),
      .active   (pix_mask),
      .head_hit (pix_head),
      .body_hit (pix_body)
   );

   snake_cell_match #(.MAX_LEN(MAX_LEN)) u_col_match (
      .cell_x   (nx),
      .cell_y   (ny),
      .seg_x    (seg_x),
      .seg_y    (seg_y),
      .active   (col_mask),
      .head_hit (col_head),
      .body_hit (col_body)
   );

   assign collide = is_wall(nx, ny) || col_head || col_body;

   always_comb begin
      pix_code = CODE_NONE;
      if (!in_range)            pix_code = CODE_NONE;
      else if (is_wall(qx, qy)) pix_code = CODE_WALL;
      else if (pix_head)        pix_code = CODE_HEAD;
      else if (pix_body)        pix_code = CODE_BODY;
   end

   assign head_x = seg_x[0];
   assign head_y = seg_y[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         heading      <= DIR_RIGHT;
         pending_grow <= 1'b0;
         length       <= LEN_INIT;
         dead         <= 1'b0;
         snake        <= CODE_NONE;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= INIT_Y;
         end
      end else begin
         snake <= pix_code;
         if (start) begin
            state        <= ST_RUN;
            heading      <= DIR_RIGHT;
            pending_grow <= 1'b0;
            length       <= LEN_INIT;
            dead         <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
               seg_x[i] <= init_x(i);
               seg_y[i] <= INIT_Y;
            end
         end else begin
            if (grow) pending_grow <= 1'b1;
            if (state == ST_RUN && move_tick) begin
               heading <= acc_dir;
               if (collide) begin
                  state <= ST_DEAD;
                  dead  <= 1'b1;
               end else begin
                  for (int i = 1; i < MAX_LEN; i++) begin
                     seg_x[i] <= seg_x[i-1];
                     seg_y[i] <= seg_y[i-1];
                  end
                  seg_x[0] <= nx;
                  seg_y[0] <= ny;
                  if (pending_grow || grow) begin
                     pending_grow <= 1'b0;
                     if (length < LEN_MAX) length <= length + 5'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_snake_body_server.sv
// tb/tb_snake_body_server.sv - directed self-checking bench for snake_body_server
module tb_snake_body_server;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] x_pos = '0;
   logic [9:0] y_pos = '0;
   logic       move_tick = 1'b0;
   logic [1:0] dir = 2'b11;
   logic       grow = 1'b0;
   logic       start = 1'b0;
   logic [1:0] snake;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic [4:0] length;
   logic       dead;

   int errors = 0;
   int checks = 0;

   snake_body_server #(.MAX_LEN(16), .INIT_LEN(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .move_tick (move_tick),
      .dir       (dir),
      .grow      (grow),
      .start     (start),
      .snake     (snake),
      .head_x    (head_x),
      .head_y    (head_y),
      .length    (length),
      .dead      (dead)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [1:0] d, input logic g);
      dir = d; grow = g; move_tick = 1'b1;
      step();
      move_tick = 1'b0; grow = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic query(input int x, input int y);
      x_pos = 10'(x); y_pos = 10'(y);
      step();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (snake !== 2'b00) begin errors++; $display("FAIL rst_snake: got %b want 00", snake); end
      checks++; if (head_x !== 6'd20 || head_y !== 5'd15) begin errors++; $display("FAIL rst_head: got (%0d,%0d) want (20,15)", head_x, head_y); end
      checks++; if (length !== 5'd3) begin errors++; $display("FAIL rst_len: got %0d want 3", length); end
      checks++; if (dead !== 1'b0) begin errors++; $display("FAIL rst_dead: got %b want 0", dead); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_pixel_query();
      query(320, 240);
      checks++; if (snake !== 2'b01) begin errors++; $display("FAIL pix_head: got %b want 01", snake); end
      query(300, 240);
      checks++; if (snake !== 2'b10) begin errors++; $display("FAIL pix_body: got %b want 10", snake); end
      query(5, 5);
      checks++; if (snake !== 2'b11) begin errors++; $display("FAIL pix_wall: got %b want 11", snake); end
      query(100, 100);
      checks++; if (snake !== 2'b00) begin errors++; $display("FAIL pix_none: got %b want 00", snake); end
      query(639, 100);
      checks++; if (snake !== 2'b11) begin errors++; $display("FAIL pix_right_wall: got %b want 11", snake); end
      query(640, 100);
      checks++; if (snake !== 2'b00) begin errors++; $display("FAIL pix_off_x: got %b want 00", snake); end
      query(320, 480);
      checks++; if (snake !== 2'b00) begin errors++; $display("FAIL pix_off_y: got %b want 00", snake); end
      tick(2'b11, 1'b0);
      checks++; if (head_x !== 6'd20) begin errors++; $display("FAIL idle_ignore: got %0d want 20", head_x); end
   endtask

   task automatic test_move();
      do_start();
      repeat (3) tick(2'b11, 1'b0);
      checks++; if (head_x !== 6'd23 || head_y !== 5'd15) begin errors++; $display("FAIL move_head: got (%0d,%0d) want (23,15)", head_x, head_y); end
      checks++; if (length !== 5'd3) begin errors++; $display("FAIL move_len: got %0d want 3", length); end
      query(320, 240);
      checks++; if (snake !== 2'b00) begin errors++; $display("FAIL move_vacated: got %b want 00", snake); end
      query(336, 240);
      checks++; if (snake !== 2'b10) begin errors++; $display("FAIL move_tail: got %b want 10", snake); end
   endtask

   task automatic test_grow();
      grow = 1'b1; step(); grow = 1'b0;
      tick(2'b11, 1'b0);
      checks++; if (length !== 5'd4 || head_x !== 6'd24) begin errors++; $display("FAIL grow_pending: got len %0d x %0d want len 4 x 24", length, head_x); end
      tick(2'b11, 1'b1);
      checks++; if (length !== 5'd5 || head_x !== 6'd25) begin errors++; $display("FAIL grow_same: got len %0d x %0d want len 5 x 25", length, head_x); end
   endtask

   task automatic test_reverse();
      tick(2'b10, 1'b0);
      checks++; if (head_x !== 6'd26 || head_y !== 5'd15) begin errors++; $display("FAIL reverse: got (%0d,%0d) want (26,15)", head_x, head_y); end
      tick(2'b11, 1'b0);
      checks++; if (head_x !== 6'd27) begin errors++; $display("FAIL reverse_after: got %0d want 27", head_x); end
   endtask

   task automatic test_wall();
      repeat (11) tick(2'b11, 1'b0);
      checks++; if (head_x !== 6'd38 || dead !== 1'b0) begin errors++; $display("FAIL wall_pre: got x %0d dead %b want x 38 dead 0", head_x, dead); end
      tick(2'b11, 1'b0);
      checks++; if (dead !== 1'b1 || head_x !== 6'd38 || head_y !== 5'd15) begin errors++; $display("FAIL wall_hit: got dead %b (%0d,%0d) want dead 1 (38,15)", dead, head_x, head_y); end
      repeat (3) tick(2'b00, 1'b0);
      checks++; if (head_x !== 6'd38 || head_y !== 5'd15 || length !== 5'd5) begin errors++; $display("FAIL dead_frozen: got (%0d,%0d) len %0d want (38,15) len 5", head_x, head_y, length); end
      do_start();
      checks++; if (dead !== 1'b0 || head_x !== 6'd20 || head_y !== 5'd15 || length !== 5'd3) begin errors++; $display("FAIL restart: got dead %b (%0d,%0d) len %0d want 0 (20,15) 3", dead, head_x, head_y, length); end
      query(288, 240);
      checks++; if (snake !== 2'b10) begin errors++; $display("FAIL restart_body: got %b want 10", snake); end
   endtask

   task automatic test_back_to_back();
      tick(2'b11, 1'b0);
      start = 1'b1; move_tick = 1'b1;
      step();
      start = 1'b0; move_tick = 1'b0;
      checks++; if (head_x !== 6'd20 || length !== 5'd3) begin errors++; $display("FAIL start_wins: got x %0d len %0d want x 20 len 3", head_x, length); end
      tick(2'b11, 1'b0);
      checks++; if (head_x !== 6'd21) begin errors++; $display("FAIL run_after_start: got %0d want 21", head_x); end
   endtask

   task automatic test_turn_collision();
      do_start();
      tick(2'b11, 1'b1);
      tick(2'b11, 1'b1);
      checks++; if (length !== 5'd5 || head_x !== 6'd22) begin errors++; $display("FAIL turn_setup: got len %0d x %0d want len 5 x 22", length, head_x); end
      tick(2'b00, 1'b0);
      tick(2'b10, 1'b0);
      checks++; if (dead !== 1'b0 || head_x !== 6'd21 || head_y !== 5'd14) begin errors++; $display("FAIL turn_path: got dead %b (%0d,%0d) want 0 (21,14)", dead, head_x, head_y); end
      tick(2'b01, 1'b0);
      checks++; if (dead !== 1'b1 || head_x !== 6'd21 || head_y !== 5'd14) begin errors++; $display("FAIL body_hit: got dead %b (%0d,%0d) want 1 (21,14)", dead, head_x, head_y); end
   endtask

   task automatic test_saturate();
      do_start();
      repeat (13) tick(2'b11, 1'b1);
      checks++; if (length !== 5'd16 || head_x !== 6'd33) begin errors++; $display("FAIL grow_full: got len %0d x %0d want len 16 x 33", length, head_x); end
      tick(2'b11, 1'b1);
      checks++; if (length !== 5'd16 || head_x !== 6'd34 || dead !== 1'b0) begin errors++; $display("FAIL grow_sat: got len %0d x %0d dead %b want 16 34 0", length, head_x, dead); end
      query(304, 240);
      checks++; if (snake !== 2'b10) begin errors++; $display("FAIL last_seg: got %b want 10", snake); end
      query(288, 240);
      checks++; if (snake !== 2'b00) begin errors++; $display("FAIL past_tail: got %b want 00", snake); end
   endtask

   task automatic test_reset_mid();
      do_start();
      tick(2'b11, 1'b0);
      query(336, 240);
      checks++; if (snake !== 2'b01) begin errors++; $display("FAIL mid_pre: got %b want 01", snake); end
      rst = 1'b1;
      #2;
      checks++; if (snake !== 2'b00 || head_x !== 6'd20 || head_y !== 5'd15 || length !== 5'd3 || dead !== 1'b0) begin
         errors++; $display("FAIL async_rst: got snake %b (%0d,%0d) len %0d dead %b want 00 (20,15) 3 0", snake, head_x, head_y, length, dead);
      end
      step();
      rst = 1'b0;
      tick(2'b11, 1'b0);
      checks++; if (head_x !== 6'd20) begin errors++; $display("FAIL rst_to_idle: got %0d want 20", head_x); end
   endtask

   initial begin
      test_reset();
      test_pixel_query();
      test_move();
      test_grow();
      test_reverse();
      test_wall();
      test_back_to_back();
      test_turn_collision();
      test_saturate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
